// File: rtl/cordic_vectoring_if.sv
// cordic_vectoring_if: start/ready/done handshake and data bus for the vectoring CORDIC.
// Rev 1.0
`default_nettype none

interface cordic_vectoring_if #(
  parameter int WIDTH = 16
);
  logic                    Start;
  logic signed [WIDTH-1:0] X_in;
  logic signed [WIDTH-1:0] Y_in;
  logic                    Ready;
  logic                    Done;
  logic [WIDTH+1:0]        Magnitude;
  logic signed [15:0]      Angle;

  modport master (
    output Start, X_in, Y_in,
    input  Ready, Done, Magnitude, Angle
  );

  modport slave (
    input  Start, X_in, Y_in,
    output Ready, Done, Magnitude, Angle
  );
endinterface

`default_nettype wire

// File: rtl/cordic_vectoring.sv
// cordic_vectoring: iterative vectoring-mode CORDIC, (X, Y) -> (K*|v|, angle), one micro-rotation per cycle.
// Rev 1.0
`default_nettype none

module cordic_vectoring #(
  parameter int WIDTH = 16,
  parameter int ITER  = 16
) (
  input  logic                Clk,
  input  logic                Reset,
  cordic_vectoring_if.slave   bus_io
);

  localparam int XW = WIDTH + 2;
  localparam logic [3:0] LAST = 4'(ITER - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ITER = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t                state_q;
  logic signed [XW-1:0]  x_q, y_q, x_d, y_d;
  logic signed [XW-1:0]  x_ext, y_ext, x_pre, y_pre;
  logic signed [15:0]    z_q, z_d, z_pre, ang_q;
  logic [XW-1:0]         mag_q;
  logic [3:0]            cnt_q;
  logic                  zero_q, ready_q, done_q;
  logic signed [15:0]    atan_w;

  function automatic logic signed [15:0] atan_lut(input logic [3:0] idx);
    case (idx)
      4'd0:    atan_lut = 16'sd8192;
      4'd1:    atan_lut = 16'sd4836;
      4'd2:    atan_lut = 16'sd2555;
      4'd3:    atan_lut = 16'sd1297;
      4'd4:    atan_lut = 16'sd651;
      4'd5:    atan_lut = 16'sd326;
      4'd6:    atan_lut = 16'sd163;
      4'd7:    atan_lut = 16'sd81;
      4'd8:    atan_lut = 16'sd41;
      4'd9:    atan_lut = 16'sd20;
      4'd10:   atan_lut = 16'sd10;
      4'd11:   atan_lut = 16'sd5;
      4'd12:   atan_lut = 16'sd3;
      4'd13:   atan_lut = 16'sd1;
      4'd14:   atan_lut = 16'sd1;
      default: atan_lut = 16'sd0;
    endcase
  endfunction

  // Left half-plane inputs are rotated by +/-pi/2 so iterations only cover (-pi/2, pi/2).
  // Extension happens before negation so the most negative input cannot overflow.
  always_comb begin
    x_ext = {{2{bus_io.X_in[WIDTH-1]}}, bus_io.X_in};
    y_ext = {{2{bus_io.Y_in[WIDTH-1]}}, bus_io.Y_in};
    x_pre = x_ext;
    y_pre = y_ext;
    z_pre = 16'sd0;
    if (bus_io.X_in[WIDTH-1]) begin
      if (!bus_io.Y_in[WIDTH-1]) begin
        x_pre = y_ext;
        y_pre = -x_ext;
        z_pre = 16'sd16384;
      end else begin
        x_pre = -y_ext;
        y_pre = x_ext;
        z_pre = -16'sd16384;
      end
    end
  end

  always_comb begin
    atan_w = atan_lut(cnt_q);
    if (!y_q[XW-1]) begin
      x_d = x_q + (y_q >>> cnt_q);
      y_d = y_q - (x_q >>> cnt_q);
      z_d = z_q + atan_w;
    end else begin
      x_d = x_q - (y_q >>> cnt_q);
      y_d = y_q + (x_q >>> cnt_q);
      z_d = z_q - atan_w;
    end
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= S_IDLE;
      ready_q <= 1'b1;
      done_q  <= 1'b0;
      mag_q   <= '0;
      ang_q   <= '0;
      cnt_q   <= '0;
      x_q     <= '0;
      y_q     <= '0;
      z_q     <= '0;
      zero_q  <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (bus_io.Start) begin
            x_q     <= x_pre;
            y_q     <= y_pre;
            z_q     <= z_pre;
            zero_q  <= (bus_io.X_in == '0) && (bus_io.Y_in == '0);
            cnt_q   <= '0;
            ready_q <= 1'b0;
            state_q <= S_ITER;
          end
        end
        S_ITER: begin
          x_q   <= x_d;
          y_q   <= y_d;
          z_q   <= z_d;
          cnt_q <= cnt_q + 4'd1;
          if (cnt_q == LAST) begin
            // A zero vector has no defined angle; report a clean (0, 0).
            mag_q   <= zero_q ? '0 : $unsigned(x_d);
            ang_q   <= zero_q ? '0 : z_d;
            done_q  <= 1'b1;
            state_q <= S_DONE;
          end
        end
        S_DONE: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
        default: begin
          done_q  <= 1'b0;
          ready_q <= 1'b1;
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign bus_io.Ready     = ready_q;
  assign bus_io.Done      = done_q;
  assign bus_io.Magnitude = mag_q;
  assign bus_io.Angle     = ang_q;

endmodule

`default_nettype wire

// File: tb/tb_cordic_vectoring.sv
// tb_cordic_vectoring: randomized scoreboard bench for the vectoring CORDIC.
// Rev 1.0
`default_nettype none

module tb_cordic_vectoring;

  localparam int  WIDTH = 16;
  localparam int  ITER  = 16;
  localparam real KGAIN = 1.646760258121;
  localparam real PI    = 3.14159265358979;

  logic Clk   = 1'b0;
  logic Reset = 1'b0;
  int   cyc   = 0;
  int   n_pass = 0;
  int   n_chk  = 0;
  int   n_done = 0;

  cordic_vectoring_if #(.WIDTH(WIDTH)) bus ();

  cordic_vectoring #(.WIDTH(WIDTH), .ITER(ITER)) dut (
    .Clk    (Clk),
    .Reset  (Reset),
    .bus_io (bus)
  );

  always #5 Clk = ~Clk;
  always @(posedge Clk) cyc <= cyc + 1;

  typedef struct {
    longint mag;
    int     ang;
    real    imag;
    int     iang;
    bit     zero;
    int     done_cyc;
    string  tag;
  } exp_t;

  exp_t sb[$];

  int atan_tab[16] = '{8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0};

  function automatic void check(input string name, input bit ok, input string detail);
    n_chk++;
    if (ok) n_pass++;
    else $display("FAIL %s: %s", name, detail);
  endfunction

  function automatic int wrapdiff(input int a, input int b);
    int d;
    d = ((((a - b) % 65536) + 65536) % 65536);
    if (d >= 32768) d -= 65536;
    return d;
  endfunction

  // Plain-arithmetic evaluation of the vectoring algorithm: quadrant fold, then ITER micro-rotations.
  function automatic void model(input int xi, input int yi, output longint mag, output int ang);
    longint x, y, z, xo, yo;
    if (xi >= 0)      begin x = xi;  y = yi;  z = 0;      end
    else if (yi >= 0) begin x = yi;  y = -xi; z = 16384;  end
    else              begin x = -yi; y = xi;  z = -16384; end
    for (int i = 0; i < ITER; i++) begin
      xo = x; yo = y;
      if (yo >= 0) begin x = xo + (yo >>> i); y = yo - (xo >>> i); z = z + atan_tab[i]; end
      else         begin x = xo - (yo >>> i); y = yo + (xo >>> i); z = z - atan_tab[i]; end
    end
    ang = wrapdiff(int'(z), 0);
    mag = x;
    if (xi == 0 && yi == 0) begin mag = 0; ang = 0; end
  endfunction

  function automatic void push(input int x, input int y, input string tag, input int dcyc);
    exp_t e;
    model(x, y, e.mag, e.ang);
    e.imag     = KGAIN * $sqrt(real'(x) * real'(x) + real'(y) * real'(y));
    e.zero     = (x == 0 && y == 0);
    e.iang     = e.zero ? 0 : int'($atan2(real'(y), real'(x)) * 32768.0 / PI);
    e.done_cyc = dcyc;
    e.tag      = tag;
    sb.push_back(e);
  endfunction

  // Monitor: pops one expectation per Done pulse; between pulses outputs must hold.
  longint last_mag = 0;
  int     last_ang = 0;
  exp_t   me;
  always @(negedge Clk) begin
    if (!Reset) begin
      last_mag = 0;
      last_ang = 0;
    end else if (bus.Done) begin
      n_done++;
      check("ready_low_in_done", bus.Ready == 1'b0, $sformatf("Ready=%0b want 0", bus.Ready));
      if (sb.size() == 0) begin
        check("unexpected_done", 1'b0, $sformatf("Done at cycle %0d with nothing pending", cyc));
      end else begin
        real mtol, atol, mdiff;
        int  adiff;
        me = sb.pop_front();
        check({"latency_", me.tag}, cyc == me.done_cyc,
              $sformatf("done cycle %0d want %0d", cyc, me.done_cyc));
        check({"mag_", me.tag}, longint'(bus.Magnitude) == me.mag,
              $sformatf("Magnitude=%0d want %0d", bus.Magnitude, me.mag));
        check({"ang_", me.tag}, int'(bus.Angle) == me.ang,
              $sformatf("Angle=%0d want %0d", bus.Angle, me.ang));
        mtol  = 6.0 + me.imag / 400.0;
        mdiff = real'(bus.Magnitude) - me.imag;
        if (mdiff < 0.0) mdiff = -mdiff;
        check({"mag_ideal_", me.tag}, mdiff <= mtol,
              $sformatf("Magnitude=%0d want %0.1f +/- %0.1f", bus.Magnitude, me.imag, mtol));
        if (!me.zero) begin
          atol  = 5.0 + 40000.0 / me.imag;
          adiff = wrapdiff(int'(bus.Angle), me.iang);
          if (adiff < 0) adiff = -adiff;
          check({"ang_ideal_", me.tag}, real'(adiff) <= atol,
                $sformatf("Angle=%0d want %0d +/- %0.1f", bus.Angle, me.iang, atol));
        end
      end
      last_mag = longint'(bus.Magnitude);
      last_ang = int'(bus.Angle);
    end else begin
      check("outputs_hold", longint'(bus.Magnitude) == last_mag && int'(bus.Angle) == last_ang,
            $sformatf("Mag/Ang=%0d/%0d want %0d/%0d", bus.Magnitude, bus.Angle, last_mag, last_ang));
    end
  end

  task automatic wait_ready();
    int t = 0;
    while (!bus.Ready && t < 200) begin @(negedge Clk); t++; end
    if (!bus.Ready) check("ready_timeout", 1'b0, "Ready=0 want 1 within 200 cycles");
  endtask

  task automatic issue(input int x, input int y, input string tag);
    wait_ready();
    bus.Start = 1'b1;
    bus.X_in  = WIDTH'(x);
    bus.Y_in  = WIDTH'(y);
    push(x, y, tag, cyc + 1 + ITER);
    @(negedge Clk);
    bus.Start = 1'b0;
    bus.X_in  = WIDTH'($urandom);
    bus.Y_in  = WIDTH'($urandom);
  endtask

  task automatic drain();
    int t = 0;
    while (sb.size() != 0 && t < 2000) begin @(negedge Clk); t++; end
    check("drain", sb.size() == 0, $sformatf("pending=%0d want 0", sb.size()));
  endtask

  function automatic int rnd16();
    return int'($urandom_range(65535)) - 32768;
  endfunction

  initial begin
    int d0, xr, yr;
    bus.Start = 1'b0;
    bus.X_in  = '0;
    bus.Y_in  = '0;
    repeat (3) @(negedge Clk);
    check("reset_state",
          bus.Ready == 1'b1 && bus.Done == 1'b0 && bus.Magnitude == '0 && bus.Angle == '0,
          $sformatf("R/D/M/A=%0b/%0b/%0d/%0d want 1/0/0/0", bus.Ready, bus.Done, bus.Magnitude, bus.Angle));
    Reset = 1'b1;
    @(negedge Clk);

    issue(1000, 0, "x1000");
    issue(7071, 7071, "q1");
    issue(-7071, 7071, "q2");
    issue(-7071, -7071, "q3");
    issue(7071, -7071, "q4");
    issue(-32768, 0, "neg_x_axis");
    issue(-32768, -32768, "corner");
    issue(32767, 32767, "max_pos");
    issue(0, 0, "zero");
    issue(0, -5, "neg_y_axis");
    drain();

    // Start held high with inputs changing every cycle: only the accept-edge inputs count.
    wait_ready();
    for (int j = 0; j < 3 * (ITER + 2); j++) begin
      xr = rnd16();
      yr = rnd16();
      bus.Start = 1'b1;
      bus.X_in  = WIDTH'(xr);
      bus.Y_in  = WIDTH'(yr);
      if (j % (ITER + 2) == 0) push(xr, yr, "held", cyc + 1 + ITER);
      @(negedge Clk);
    end
    bus.Start = 1'b0;
    drain();

    // Abort mid-operation with reset: no Done may follow.
    issue(1234, -567, "pre_abort");
    drain();
    wait_ready();
    bus.Start = 1'b1;
    bus.X_in  = WIDTH'(20000);
    bus.Y_in  = WIDTH'(-3000);
    @(negedge Clk);
    bus.Start = 1'b0;
    repeat (4) @(negedge Clk);
    Reset = 1'b0;
    d0 = n_done;
    repeat (3) @(negedge Clk);
    check("abort_reset_state",
          bus.Ready == 1'b1 && bus.Done == 1'b0 && bus.Magnitude == '0 && bus.Angle == '0,
          $sformatf("R/D/M/A=%0b/%0b/%0d/%0d want 1/0/0/0", bus.Ready, bus.Done, bus.Magnitude, bus.Angle));
    Reset = 1'b1;
    repeat (ITER + 4) @(negedge Clk);
    check("no_done_after_abort", n_done == d0, $sformatf("done pulses=%0d want %0d", n_done - d0, 0));
    check("ready_after_abort", bus.Ready == 1'b1, $sformatf("Ready=%0b want 1", bus.Ready));

    for (int k = 0; k < 24; k++) issue(rnd16(), rnd16(), "rand");
    drain();
    repeat (4) @(negedge Clk);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running at %0t, want finished", $time);
    $fatal(1);
  end

endmodule

`default_nettype wire

// File: doc/cordic_vectoring.md
Name: cordic_vectoring

Overview:
Iterative CORDIC engine in vectoring mode. It is the inverse direction of the rotation datapath (CORDIC_X/Y/Z stages built on ADD_SUB): it takes a Cartesian vector (X, Y) and returns its polar form, magnitude times CORDIC gain plus angle. It is a sequential, one-iteration-per-cycle unit with a start/ready/done handshake, used for phase and magnitude recovery downstream of the rotation pipeline.

Parameters:
WIDTH, 16, input coordinate width (signed two's complement)
ITER, 16, number of micro-rotations (1..16; the angle LUT holds 16 entries)

Ports:
Clk  input  1  system clock, rising edge
Reset  input  1  synchronous, active-low reset
Start  input  1  request; sampled only when Ready=1
X_in  input  WIDTH  signed X coordinate
Y_in  input  WIDTH  signed Y coordinate
Ready  output  1  high in IDLE; engine accepts Start
Done  output  1  one-cycle pulse; results valid
Magnitude  output  WIDTH+2  unsigned, K·sqrt(X²+Y²), K≈1.64676, gain not compensated
Angle  output  16  signed binary angle; 32768 LSB = pi; range [-pi, pi)

Behaviour:
- Reset (Reset=0 at a rising edge): state=IDLE, Ready=1, Done=0, Magnitude=0, Angle=0, iteration counter=0. Reset overrides everything, including a mid-operation abort. The in-flight result is discarded and no Done is issued.
- States: IDLE -> ITER -> DONE -> IDLE.
- IDLE: Ready=1. At an edge with Start=1, the engine captures the inputs with pre-rotation applied, clears the counter i and goes to ITER. Start=0 keeps it in IDLE.
- Pre-rotation at capture (internal x, y are WIDTH+2 signed; z is 16-bit):
  - X_in>=0: x=X, y=Y, z=0.
  - X_in<0 and Y_in>=0: x=Y, y=-X, z=+16384.
  - X_in<0 and Y_in<0: x=-Y, y=X, z=-16384.
  - Sign-extend before negating, so -(-2^(WIDTH-1)) does not overflow.
- ITER: one micro-rotation per edge, i=0..ITER-1. Shifts are arithmetic.
  - If y>=0: x+=y>>>i, y-=x>>>i, z+=atan_i.
  - Otherwise: x-=y>>>i, y+=x>>>i, z-=atan_i.
  - All updates use the old x and y values.
- atan_i = round(atan(2^-i)·32768/pi): 8192, 4836, 2555, 1297, 651, 326, 163, 81, 41, 20, 10, 5, 3, 1, 1, 0.
- z wraps modulo 2^16; wrap near ±pi is legal.
- At the edge performing iteration ITER-1, Magnitude and Angle are loaded with the post-iteration x and z, and the state goes to DONE.
- DONE: Done=1 and Ready=0 for exactly one cycle, then IDLE.
- Magnitude and Angle hold their values until the next DONE load or reset.
- Latency: Done is high in the cycle following the ITER-th edge after the accepting edge. One operation every ITER+2 cycles.
- Start while Ready=0 (ITER or DONE) is ignored. It is not queued, and X_in/Y_in changes have no effect.
- Zero vector: X_in=Y_in=0 sets a zero flag at capture. The iterations still run (fixed latency), and the engine outputs Magnitude=0 and Angle=0.
- Width: x never exceeds 2^(WIDTH-1)·sqrt2·K < 2^(WIDTH+1), so WIDTH+2 bits cannot overflow. Magnitude is x reinterpreted as unsigned (always >=0 after iteration 0).

Test Plan:
1. Reset held low 3 cycles mid-operation (Start accepted 5 cycles earlier) -> Ready=1, Done=0, Magnitude=0, Angle=0. No Done follows.
2. X=1000, Y=0 -> Done exactly ITER cycles after the accept-edge cycle (cycle after 16th edge), Magnitude=1647±3, Angle=0±4.
3. Four quadrants, |v|=10000:
   - (7071, 7071) -> Angle 8192±4
   - (-7071, 7071) -> 24576±4
   - (-7071, -7071) -> -24576±4
   - (7071, -7071) -> -8192±4
   - Magnitude 16468±20 in all four cases.
4. Corners (-32768, 0) and (-32768, -32768):
   - (-32768, 0) -> Angle within 4 LSB of ±32768 (mod 2^16), Magnitude 53962±40.
   - (-32768, -32768) -> Angle -24576±4, Magnitude 76315±60, no overflow.
5. Zero vector (0, 0) -> Done at normal latency, Magnitude=0, Angle=0.
6. Handshake:
   - Start held high continuously -> accepts spaced exactly ITER+2 cycles; inputs changed during ITER do not alter the result.
   - Single Start pulse -> exactly one Done pulse.
   - Outputs stable between Done pulses.
